// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared UART definitions: FSM encodings, line levels and the baud divider derivation.
// Used by both the transmit and receive paths.
package mfp_uart_transmitter_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Truncating division: the bit period is always a whole number of clocks.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO; rd_data shows the head whenever empty is low.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module mfp_uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        push_ok, pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock)
    if (push_ok) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// UART transmitter: byte handshake into a FIFO, serialised as 8N1 (or 8E1 when
// MFP_UART_TX_PARITY_EN is defined) frames on a registered tx line.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [7:0]                         byte_data,
  input  logic                               byte_valid,
  output logic                               byte_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int CPB   = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int DIV_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CPB - 1);

  uart_state_e      state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic             fifo_full, fifo_empty, pop, bit_end;
`ifdef MFP_UART_TX_PARITY_EN
  logic             parity;
`endif

  mfp_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (byte_valid),
    .wr_data (byte_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end    = (div == DIV_LAST);
  // Pop from idle, or at the end of a stop bit so frames run back-to-back.
  assign pop        = !fifo_empty && ((state == UART_IDLE) || (state == UART_STOP && bit_end));
  assign byte_ready = !fifo_full;
  assign busy       = (state != UART_IDLE) || !fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= UART_IDLE;
      tx      <= LINE_IDLE;
      div     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        UART_IDLE: begin
          div <= '0;
          tx  <= LINE_IDLE;
          if (pop) begin
            shift <= head;
            tx    <= LINE_START;
            state <= UART_START;
`ifdef MFP_UART_TX_PARITY_EN
            parity <= ^head;
`endif
          end
        end
        UART_START: begin
          if (bit_end) begin
            div     <= '0;
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= UART_DATA;
          end else div <= div + 1'b1;
        end
        UART_DATA: begin
          if (bit_end) begin
            div <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
              tx    <= parity;
              state <= UART_PARITY;
`else
              tx    <= LINE_STOP;
              state <= UART_STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else div <= div + 1'b1;
        end
`ifdef MFP_UART_TX_PARITY_EN
        UART_PARITY: begin
          if (bit_end) begin
            div   <= '0;
            tx    <= LINE_STOP;
            state <= UART_STOP;
          end else div <= div + 1'b1;
        end
`endif
        UART_STOP: begin
          if (bit_end) begin
            div <= '0;
            if (pop) begin
              shift <= head;
              tx    <= LINE_START;
              state <= UART_START;
`ifdef MFP_UART_TX_PARITY_EN
              parity <= ^head;
`endif
            end else state <= UART_IDLE;
          end else div <= div + 1'b1;
        end
        default: begin
          state <= UART_IDLE;
          tx    <= LINE_IDLE;
          div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Bench for mfp_uart_transmitter: directed steps plus random bursts, with a line
// decoder that checks every frame against a queue of expected bytes.
module tb_mfp_uart_transmitter;

  localparam int CF    = 1000000;
  localparam int BR    = 100000;
  localparam int CPB   = CF / BR;
  localparam int DEPTH = 16;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, tx, busy;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;

  int         vectors = 0;
  int         errors  = 0;
  int         frames  = 0;
  int         queued  = 0;
  logic [7:0] exp_q[$];

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY (CF),
    .BAUD_RATE       (BR),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Line image of one frame, first bit on the wire at index 0.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
`ifdef MFP_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    exp_q.push_back(b);
    queued++;
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  // Line decoder: every tx sample of a frame must match the expected bit.
  initial begin : monitor
    logic [7:0]       e;
    logic [NBITS-1:0] fb;
    logic             bad, seen, aborted;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1 || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        repeat (FRAME_CYC) @(negedge clock);
        continue;
      end
      e = exp_q.pop_front();
      fb = frame_bits(e);
      aborted = 1'b0;
      for (int b = 0; b < NBITS && !aborted; b++) begin
        bad = 1'b0;
        seen = fb[b];
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clock);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== fb[b] && !bad) begin
            bad = 1'b1;
            seen = tx;
          end
        end
        if (!aborted) check($sformatf("frame_%02h_bit%0d", e, b), {31'd0, seen}, {31'd0, fb[b]});
      end
      if (!aborted) frames++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic quiet;
    int   n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", fifo_level, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single byte from idle: tx falls one edge after acceptance
    push(8'h55);
    check("lat_tx_n0", {31'd0, tx}, 32'd1);
    check("lat_busy_n0", {31'd0, busy}, 32'd1);
    check("lat_level_n0", fifo_level, 32'd1);
    @(negedge clock);
    check("lat_tx_n1", {31'd0, tx}, 32'd0);
    check("lat_level_n1", fifo_level, 32'd0);
    repeat (FRAME_CYC - 1) @(negedge clock);
    check("f55_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("f55_busy_done", {31'd0, busy}, 32'd0);
    check("f55_tx_done", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clock);

    // Two bytes back-to-back
    push(8'hA3);
    push(8'h0F);
    check("b2b_level_n1", fifo_level, 32'd1);
    repeat (FRAME_CYC - 1) @(negedge clock);
    check("b2b_level_pre", fifo_level, 32'd1);
    @(negedge clock);
    check("b2b_level_post", fifo_level, 32'd0);
    repeat (FRAME_CYC - 1) @(negedge clock);
    check("b2b_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("b2b_busy_done", {31'd0, busy}, 32'd0);
    wait_idle(10, "b2b");

    // 18 cycles of byte_valid: 17 accepted, then full
    for (int i = 0; i < 18; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      if (i < 17) begin
        exp_q.push_back(byte_data);
        queued++;
      end
      @(negedge clock);
      if (i == 16) begin
        check("full_level", fifo_level, 32'd16);
        check("full_ready", {31'd0, byte_ready}, 32'd0);
      end
    end
    byte_valid = 1'b0;
    // Push exactly on the edge the FSM pops: rejected, level drops to 15
    repeat (FRAME_CYC - 17) @(negedge clock);
    check("fullpop_level_pre", fifo_level, 32'd16);
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge clock);
    byte_valid = 1'b0;
    check("fullpop_level_post", fifo_level, 32'd15);
    check("fullpop_ready", {31'd0, byte_ready}, 32'd1);
    wait_idle(17 * FRAME_CYC, "full");

    // Reset during data bit 3 with bytes queued
    for (int i = 0; i < 5; i++) push(8'($urandom));
    repeat (41) @(negedge clock);
    #2;
    reset_n = 1'b0;
    queued -= exp_q.size() + 1;
    exp_q.delete();
    #1;
    check("mrst_tx", {31'd0, tx}, 32'd1);
    check("mrst_level", fifo_level, 32'd0);
    check("mrst_ready", {31'd0, byte_ready}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (300) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    check("mrst_quiet", {31'd0, quiet}, 32'd1);
    push(8'h5A);
    wait_idle(2 * FRAME_CYC, "mrst_revive");

    // Parity-sensitive patterns (odd and even bit counts)
    push(8'h07);
    wait_idle(2 * FRAME_CYC, "p07");
    push(8'h03);
    wait_idle(2 * FRAME_CYC, "p03");

    // Random bursts with random gaps
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        push(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      wait_idle(10 * FRAME_CYC, $sformatf("rnd%0d", r));
    end

    check("frame_count", frames, queued);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
